// File: rtl/security_fsm.sv
// security_fsm: car anti-theft sequencer.
// Watches the ignition and door switches, drives the siren and the status LED,
// and starts the 1 Hz interval timer with an interval code. Every output is
// registered, and all of them change together with the state register.
module security_fsm #(
    parameter int T_ARM_DELAY       = 6,
    parameter int T_DRIVER_DELAY    = 8,
    parameter int T_PASSENGER_DELAY = 15,
    parameter int T_ALARM_ON        = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       driverDoor,
    input  logic       passengerDoor,
    input  logic       clock1Hz,
    input  logic       expired,
    output logic       startTimer,
    output logic [3:0] value,
    output logic       siren,
    output logic       statusLED
);

    // The timer interface is 4 bits wide. Larger parameters keep only their
    // low 4 bits.
    localparam logic [3:0] CODE_ARM       = 4'(T_ARM_DELAY);
    localparam logic [3:0] CODE_DRIVER    = 4'(T_DRIVER_DELAY);
    localparam logic [3:0] CODE_PASSENGER = 4'(T_PASSENGER_DELAY);
    localparam logic [3:0] CODE_ALARM     = 4'(T_ALARM_ON);

    typedef enum logic [2:0] {
        ARMED,
        TRIGGERED,
        SOUND_ALARM,
        ALARM_HOLD,
        DISARMED,
        ARM_WAIT
    } state_t;

    state_t     state, state_n;
    logic       waiting, waiting_n;
    logic       door_seen, door_seen_n;
    logic       start_n;
    logic [3:0] value_n;
    logic       siren_n;
    logic       led_n;

    logic door_open;
    logic timeout;

    assign door_open = driverDoor | passengerDoor;
    // An expiry is honoured only if this FSM started the interval that is
    // now ending. Pulses from an abandoned or pre-reset interval are dropped.
    assign timeout   = expired & waiting;

    // Next-state, timer request and next-output decode
    always_comb begin
        state_n     = state;
        start_n     = 1'b0;
        value_n     = value;
        door_seen_n = door_seen;

        unique case (state)
            ARMED: begin
                if (ignition) begin
                    state_n     = DISARMED;
                    door_seen_n = 1'b0;
                end else if (driverDoor) begin
                    // The driver door is checked first, so it wins when both
                    // doors open in the same cycle.
                    state_n = TRIGGERED;
                    start_n = 1'b1;
                    value_n = CODE_DRIVER;
                end else if (passengerDoor) begin
                    state_n = TRIGGERED;
                    start_n = 1'b1;
                    value_n = CODE_PASSENGER;
                end
            end
            TRIGGERED: begin
                // Door activity is ignored during the entry grace period.
                if (ignition) begin
                    state_n     = DISARMED;
                    door_seen_n = 1'b0;
                end else if (timeout) begin
                    state_n = SOUND_ALARM;
                end
            end
            SOUND_ALARM: begin
                // Ignition cannot silence the alarm.
                if (!door_open) begin
                    state_n = ALARM_HOLD;
                    start_n = 1'b1;
                    value_n = CODE_ALARM;
                end
            end
            ALARM_HOLD: begin
                // A door opening wins over an expiry in the same cycle.
                if (door_open) begin
                    state_n = SOUND_ALARM;
                end else if (timeout) begin
                    state_n = ARMED;
                end
            end
            DISARMED: begin
                // Re-arm sequence: ignition off, then driver door opens,
                // then driver door closes.
                if (ignition) begin
                    door_seen_n = 1'b0;
                end else if (!door_seen) begin
                    if (driverDoor) door_seen_n = 1'b1;
                end else if (!driverDoor) begin
                    state_n = ARM_WAIT;
                    start_n = 1'b1;
                    value_n = CODE_ARM;
                end
            end
            ARM_WAIT: begin
                if (ignition) begin
                    state_n     = DISARMED;
                    door_seen_n = 1'b0;
                end else if (door_open) begin
                    // The exit sequence has already started, so a closed
                    // driver door completes it again.
                    state_n     = DISARMED;
                    door_seen_n = 1'b1;
                end else if (timeout) begin
                    state_n = ARMED;
                end
            end
            default: begin
                state_n     = ARMED;
                door_seen_n = 1'b0;
            end
        endcase

        // Any new interval arms the expiry. Leaving a state without starting
        // a new interval abandons the old one.
        if (start_n)               waiting_n = 1'b1;
        else if (state_n != state) waiting_n = 1'b0;
        else                       waiting_n = waiting;

        siren_n = (state_n == SOUND_ALARM) || (state_n == ALARM_HOLD);

        unique case (state_n)
            // The LED blinks only while the car stays armed. On entry to
            // ARMED it keeps its previous level.
            ARMED:                              led_n = statusLED ^ (clock1Hz && state == ARMED);
            TRIGGERED, SOUND_ALARM, ALARM_HOLD: led_n = 1'b1;
            default:                            led_n = 1'b0;
        endcase
    end

    // State, flag and registered-output update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ARMED;
            waiting    <= 1'b0;
            door_seen  <= 1'b0;
            startTimer <= 1'b0;
            value      <= 4'd0;
            siren      <= 1'b0;
            statusLED  <= 1'b0;
        end else begin
            state      <= state_n;
            waiting    <= waiting_n;
            door_seen  <= door_seen_n;
            startTimer <= start_n;
            value      <= value_n;
            siren      <= siren_n;
            statusLED  <= led_n;
        end
    end

endmodule
